regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Write-side front end for the 16x16 register file. It is the producer that drives the file's single write port (WE/WriteReg/WriteData).
- Accepts writeback results from two producers, ALU and load unit, over valid/ready. Buffers them in a small in-order FIFO and retires one write per cycle.
- Reports per-register "write pending" hazard flags for the two decode read addresses, so issue logic can stall on RAW.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- DATA_W, 16, register data width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this edge.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this edge.
- mem_reg  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- WE  out  1  register-file write enable (registered).
- WriteReg  out  ADDR_W  register-file write index (registered).
- WriteData  out  DATA_W  register-file write data (registered).
- AReg_q  in  ADDR_W  decode A-operand index for hazard query.
- BReg_q  in  ADDR_W  decode B-operand index for hazard query.
- a_pending  out  1  a write to AReg_q is queued or in the output stage.
- b_pending  out  1  a write to BReg_q is queued or in the output stage.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n.
- While rst_n=0:
  - At each edge: pointers, count <= 0; WE <= 0; WriteReg <= 0; WriteData <= 0.
  - alu_ready=mem_ready=0 combinationally.
  - Reset mid-operation discards all queued entries; the output stage is cleared, so no further writes occur.
- Readiness uses the registered count only; a same-cycle pop does not free space.
  - free = DEPTH - count.
  - alu_ready = rst_n & (free>=1).
  - mem_ready = rst_n & (free >= (alu_valid ? 2 : 1)).
- Enqueue, on an edge with valid&ready:
  - Both accepted: ALU entry written first (older), load entry second.
  - Order within the FIFO is strict acceptance order.
- Drain, every edge:
  - If count>0 (pre-edge): pop the head into {WE<=1, WriteReg, WriteData}.
  - Else: WE<=0; WriteReg and WriteData hold their values.
  - At most one pop per edge. WE is high for exactly one cycle per entry.
- count update: count <= count + pushes(0..2) - pop(0/1). It never exceeds DEPTH and never underflows.
- Latency on an empty queue:
  - Request accepted at edge E.
  - WE=1 with that data during the cycle after edge E+1.
  - Register file commits at edge E+2.
- Hazard flags, combinational:
  - a_pending = (any valid FIFO entry with reg==AReg_q) | (WE & WriteReg==AReg_q). b_pending likewise for BReg_q.
  - A flag deasserts in the cycle after the commit edge.
- Multiple queued writes to the same register retire in order; the last one wins. No coalescing.
- R0 receives no special treatment; writes to index 0 are passed through.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W constants.
  - wb_entry_t typedef {reg[ADDR_W], data[DATA_W]}.
- One sub-module, wb_dual_push_fifo: DEPTH-entry synchronous FIFO with two ordered push ports, one pop port, occupancy output, and a per-entry valid/reg view for the hazard compare.
- The top level holds the ready logic, the output stage and the hazard comparators.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> WE=0, WriteReg=0, WriteData=0, empty=1, count=0, alu_ready=mem_ready=0. Release -> both readies 1.
- Single ALU write: alu_reg=3, alu_data=0x1234 accepted at edge E -> WE=1, WriteReg=3, WriteData=0x1234 for exactly the one cycle after E+1, then WE=0 and empty=1.
- Simultaneous: ALU R5=0xAAAA and load R6=0x5555 in the same cycle -> two consecutive WE cycles, R5/0xAAAA then R6/0x5555.
- Fill and backpressure: both producers valid every cycle with incrementing data ->
  - count climbs.
  - mem_ready drops when free<2 while alu_ready stays 1 until full.
  - All accepted entries retire in order with no loss or duplication.
- Hazard: queue a write to R12 with AReg_q=12, BReg_q=11 -> a_pending=1 from the cycle after acceptance through the WE cycle, 0 the cycle after commit; b_pending stays 0.
- Mid-operation reset: 3 entries queued, assert rst_n=0 for one edge -> next cycle count=0, WE=0, and no writes of the discarded entries ever appear.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback queue.
package wb_pkg;

   // Register data width and register index width (16 registers).
   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   // One queued register write: destination index plus data.
   typedef struct packed {
      logic [ADDR_W-1:0] reg_idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_dual_push_fifo.sv
// Synchronous FIFO with two ordered push ports (port 0 is older), one pop port,
// an occupancy output and a per-entry valid/register view for hazard compares.
module wb_dual_push_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push0_i,
   input  wb_entry_t                       push0_entry_i,
   input  logic                            push1_i,
   input  wb_entry_t                       push1_entry_i,
   input  logic                            pop_i,
   output wb_entry_t                       head_o,
   output logic [CNT_W-1:0]                count_o,
   output logic [DEPTH-1:0]                entry_valid_o,
   output logic [DEPTH-1:0][ADDR_W-1:0]    entry_reg_o
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [PTR_W-1:0]   push1_ptr_d;

   // Port 1 lands right behind port 0 when both push in the same cycle.
   assign push1_ptr_d = wr_ptr_q + PTR_W'(push0_i);

   // Entry storage; no reset needed since validity comes from the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push0_i && (wr_ptr_q == PTR_W'(i))) begin
            mem_q[i] <= push0_entry_i;
         end else if (push1_i && (push1_ptr_d == PTR_W'(i))) begin
            mem_q[i] <= push1_entry_i;
         end
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap freely.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
         count_q  <= count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // An entry is live when its distance from the read pointer is below the occupancy.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_view
      logic [PTR_W-1:0] offset_d;
      assign offset_d          = PTR_W'(gi) - rd_ptr_q;
      assign entry_valid_o[gi] = ({1'b0, offset_d} < count_q);
      assign entry_reg_o[gi]   = mem_q[gi].reg_idx;
   end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side front end of the register file: merges ALU and load writebacks
// into an in-order queue, retires one write per cycle and flags RAW hazards.
module regfile_writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_reg,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_reg,
   input  logic [DATA_W-1:0] mem_data,
   output logic              WE,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] AReg_q,
   input  logic [ADDR_W-1:0] BReg_q,
   output logic              a_pending,
   output logic              b_pending,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic                          alu_push_d;
   logic                          mem_push_d;
   logic                          pop_d;
   wb_entry_t                     alu_entry_d;
   wb_entry_t                     mem_entry_d;
   wb_entry_t                     head_d;
   logic [CNT_W-1:0]              count_d;
   logic [DEPTH-1:0]              entry_valid_d;
   logic [DEPTH-1:0][ADDR_W-1:0]  entry_reg_d;
   logic [DEPTH-1:0]              a_hit_d;
   logic [DEPTH-1:0]              b_hit_d;

   logic                          we_q;
   logic [ADDR_W-1:0]             wreg_q;
   logic [DATA_W-1:0]             wdata_q;

   // Readiness looks only at the registered occupancy, so a pop in the same
   // cycle never frees space; the load port needs two slots when ALU also asks.
   assign alu_ready = rst_n && (count_d < CNT_W'(DEPTH));
   assign mem_ready = rst_n && (alu_valid ? (count_d <= CNT_W'(DEPTH - 2))
                                          : (count_d <  CNT_W'(DEPTH)));

   assign alu_push_d  = alu_valid && alu_ready;
   assign mem_push_d  = mem_valid && mem_ready;
   assign pop_d       = rst_n && (count_d != '0);
   assign alu_entry_d = '{reg_idx: alu_reg, data: alu_data};
   assign mem_entry_d = '{reg_idx: mem_reg, data: mem_data};

   // ALU goes on the older push port so a same-cycle pair keeps ALU-first order.
   wb_dual_push_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push0_i       (alu_push_d),
      .push0_entry_i (alu_entry_d),
      .push1_i       (mem_push_d),
      .push1_entry_i (mem_entry_d),
      .pop_i         (pop_d),
      .head_o        (head_d),
      .count_o       (count_d),
      .entry_valid_o (entry_valid_d),
      .entry_reg_o   (entry_reg_d)
   );

   // Output stage: present the popped head to the register file for one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
      end else if (pop_d) begin
         we_q    <= 1'b1;
         wreg_q  <= head_d.reg_idx;
         wdata_q <= head_d.data;
      end else begin
         we_q    <= 1'b0;
      end
   end

   assign WE        = we_q;
   assign WriteReg  = wreg_q;
   assign WriteData = wdata_q;

   assign count = count_d;
   assign full  = (count_d == CNT_W'(DEPTH));
   assign empty = (count_d == '0);

   // Per-entry hazard compares against both decode operand indices.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign a_hit_d[gi] = entry_valid_d[gi] && (entry_reg_d[gi] == AReg_q);
      assign b_hit_d[gi] = entry_valid_d[gi] && (entry_reg_d[gi] == BReg_q);
   end

   // The output stage still counts as pending until its commit edge has passed.
   assign a_pending = (|a_hit_d) || (we_q && (wreg_q == AReg_q));
   assign b_pending = (|b_hit_d) || (we_q && (wreg_q == BReg_q));

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized self-checking bench for regfile_writeback_queue against a queue-based model.
module tb_regfile_writeback_queue;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alu_valid = 1'b0, mem_valid = 1'b0;
   logic              alu_ready, mem_ready;
   logic [ADDR_W-1:0] alu_reg = '0, mem_reg = '0;
   logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
   logic              WE;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] AReg_q = '0, BReg_q = '0;
   logic              a_pending, b_pending;
   logic [CNT_W-1:0]  count;
   logic              full, empty;

   int tests_run = 0;
   int tests_failed = 0;

   // Model state: pending writes in acceptance order, plus the register-file port.
   logic [ADDR_W+DATA_W-1:0] mq[$];
   logic              m_we = 1'b0;
   logic [ADDR_W-1:0] m_wreg = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   bit                m_known = 1'b0;

   always #5 clk = ~clk;

   regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_reg   (mem_reg),
      .mem_data  (mem_data),
      .WE        (WE),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .AReg_q    (AReg_q),
      .BReg_q    (BReg_q),
      .a_pending (a_pending),
      .b_pending (b_pending),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit pend(input logic [ADDR_W-1:0] r);
      bit hit = m_we && (m_wreg == r);
      foreach (mq[i]) if (mq[i][ADDR_W+DATA_W-1:DATA_W] == r) hit = 1'b1;
      return hit;
   endfunction

   // One clock cycle: drive inputs, check all outputs against the model, advance the model.
   task automatic step(input bit rst, input bit av, input logic [ADDR_W-1:0] ar,
                       input logic [DATA_W-1:0] ad, input bit mv,
                       input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
      int  free;
      bit  e_ar, e_mr;
      @(negedge clk);
      rst_n = ~rst; alu_valid = av; alu_reg = ar; alu_data = ad;
      mem_valid = mv; mem_reg = mr; mem_data = md; AReg_q = ra; BReg_q = rb;
      #1;
      free = DEPTH - mq.size();
      e_ar = !rst && (free >= 1);
      e_mr = !rst && (free >= (av ? 2 : 1));
      check("alu_ready", alu_ready, e_ar);
      check("mem_ready", mem_ready, e_mr);
      if (m_known) begin
         check("WE", WE, m_we);
         check("WriteReg", WriteReg, m_wreg);
         check("WriteData", WriteData, m_wdata);
         check("count", count, mq.size());
         check("full", full, mq.size() == DEPTH);
         check("empty", empty, mq.size() == 0);
         check("a_pending", a_pending, pend(ra));
         check("b_pending", b_pending, pend(rb));
         if (m_we)
            $display("[TB] write R%0d <= 0x%04h", m_wreg, m_wdata);
      end
      // Model of the coming edge.
      if (rst) begin
         mq.delete();
         m_we = 1'b0; m_wreg = '0; m_wdata = '0;
         m_known = 1'b1;
      end else begin
         if (mq.size() > 0) begin
            logic [ADDR_W+DATA_W-1:0] h = mq.pop_front();
            m_we = 1'b1; m_wreg = h[ADDR_W+DATA_W-1:DATA_W]; m_wdata = h[DATA_W-1:0];
         end else begin
            m_we = 1'b0;
         end
         if (av && e_ar) mq.push_back({ar, ad});
         if (mv && e_mr) mq.push_back({mr, md});
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ra, rb);
   endtask

   initial begin
      // Reset for two edges, then release.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2, 0, 0);
      // Single ALU write R3 = 0x1234.
      step(0, 1, 4'd3, 16'h1234, 0, 0, 0, 3, 0);
      idle(4, 3, 0);
      // Simultaneous ALU R5 and load R6.
      step(0, 1, 4'd5, 16'hAAAA, 1, 4'd6, 16'h5555, 5, 6);
      idle(4, 5, 6);
      // Fill and backpressure with incrementing data.
      for (int i = 0; i < 10; i++)
         step(0, 1, 4'(i), 16'(2*i), 1, 4'(i+8), 16'(2*i+1), 4'(i), 4'(i+8));
      idle(7, 0, 8);
      // Hazard on R12 with B-operand R11.
      step(0, 1, 4'd12, 16'hC0DE, 0, 0, 0, 12, 11);
      idle(5, 12, 11);
      // Three entries queued, then a one-edge reset.
      step(0, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202, 1, 2);
      step(0, 1, 4'd7, 16'h0707, 1, 4'd9, 16'h0909, 7, 9);
      step(1, 0, 0, 0, 0, 0, 0, 7, 9);
      idle(5, 7, 9);
      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 60, 4'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(0, 99) < 55, 4'($urandom_range(0, 7)), 16'($urandom),
              4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      idle(8, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
